// File: rtl/page_walker_pkg.sv
// Shared definitions for the two-level page-table walker: PTE field layout,
// state encoding and the PTE address arithmetic.
package page_walker_pkg;

    localparam logic [31:0] PT_BASE_DEFAULT = 32'h0010_0000;
    localparam int          PTE_VALID_BIT   = 0;
    localparam int          PTE_PFN_MSB     = 31;
    localparam int          PTE_PFN_LSB     = 12;

    typedef enum logic [2:0] {
        PTW_IDLE  = 3'd0,
        PTW_L1    = 3'd1,
        PTW_L2    = 3'd2,
        PTW_FILL  = 3'd3,
        PTW_FAULT = 3'd4
    } ptw_state_e;

    function automatic logic pte_valid(input logic [31:0] pte);
        return pte[PTE_VALID_BIT];
    endfunction

    function automatic logic [19:0] pte_pfn(input logic [31:0] pte);
        return pte[PTE_PFN_MSB:PTE_PFN_LSB];
    endfunction

    // Both helpers wrap modulo 2^32; carries out of bit 31 are dropped.
    function automatic logic [31:0] l1_pte_addr(input logic [31:0] base, input logic [9:0] l1_idx);
        return base + {20'd0, l1_idx, 2'b00};
    endfunction

    function automatic logic [31:0] l2_pte_addr(input logic [19:0] frame, input logic [9:0] l2_idx);
        return {frame, 12'd0} + {20'd0, l2_idx, 2'b00};
    endfunction

endpackage

// File: rtl/page_walker_if.sv
// Bundle of the walker's TLB-side and memory-side signals. The slave view is
// the walker itself; the master view is the TLB/memory environment around it.
interface page_walker_if;

    logic        miss;
    logic [31:0] miss_vaddr;
    logic        busy;
    logic        done;
    logic        fault;
    logic        write_enable;
    logic [31:0] wr_vaddr;
    logic [31:0] wr_paddr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    modport slave (
        input  miss, miss_vaddr, mem_ack, mem_data,
        output busy, done, fault, write_enable, wr_vaddr, wr_paddr, mem_req, mem_addr
    );

    modport master (
        output miss, miss_vaddr, mem_ack, mem_data,
        input  busy, done, fault, write_enable, wr_vaddr, wr_paddr, mem_req, mem_addr
    );

endinterface

// File: rtl/page_walker.sv
// Two-level page-table walker: on a TLB miss it reads the L1 and L2 PTEs and
// either writes the translation into the TLB or pulses fault.
module page_walker
    import page_walker_pkg::*;
#(
    parameter logic [31:0] PT_BASE = PT_BASE_DEFAULT,
    parameter logic [23:0] ALIAS   = "PTW"
) (
    input  logic          clk,
    input  logic          reset,
    page_walker_if.slave  bus
);

    if (PT_BASE[1:0] != 2'b00 || ALIAS == 24'd0) begin : g_bad_cfg
        $error("page_walker: PT_BASE must be word aligned and ALIAS non-empty");
    end

    ptw_state_e  state_q, state_d;
    logic [19:0] vpn_q, vpn_d;
    logic [19:0] pte1_q, pte1_d;
    logic [19:0] pfn_q, pfn_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        we_q, we_d;
    logic [31:0] wr_vaddr_q, wr_vaddr_d;
    logic [31:0] wr_paddr_q, wr_paddr_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        ack_s;

    logic unused_vaddr_offset_s;
    assign unused_vaddr_offset_s = ^bus.miss_vaddr[11:0];

    assign ack_s = mem_req_q & bus.mem_ack;

    // Next-state logic; every output is registered from the next state so it
    // changes on the same edge as the state itself.
    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        pte1_d     = pte1_q;
        pfn_d      = pfn_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wr_vaddr_d = wr_vaddr_q;
        wr_paddr_d = wr_paddr_q;

        case (state_q)
            PTW_IDLE: begin
                if (bus.miss) begin
                    vpn_d      = bus.miss_vaddr[31:12];
                    mem_req_d  = 1'b1;
                    mem_addr_d = l1_pte_addr(PT_BASE, bus.miss_vaddr[31:22]);
                    state_d    = PTW_L1;
                end else begin
                    mem_req_d  = 1'b0;
                end
            end
            PTW_L1: begin
                if (ack_s) begin
                    mem_req_d = 1'b0;
                    pte1_d    = pte_pfn(bus.mem_data);
                    state_d   = pte_valid(bus.mem_data) ? PTW_L2 : PTW_FAULT;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            // The first L2 cycle has mem_req low; the L2 address is formed
            // there from the already-registered L1 frame.
            PTW_L2: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = l2_pte_addr(pte1_q, vpn_q[9:0]);
                end else if (ack_s) begin
                    mem_req_d = 1'b0;
                    if (pte_valid(bus.mem_data)) begin
                        pfn_d   = pte_pfn(bus.mem_data);
                        state_d = PTW_FILL;
                    end else begin
                        state_d = PTW_FAULT;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            PTW_FILL: begin
                mem_req_d = 1'b0;
                state_d   = PTW_IDLE;
            end
            PTW_FAULT: begin
                mem_req_d = 1'b0;
                state_d   = PTW_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = PTW_IDLE;
            end
        endcase

        busy_d  = (state_d != PTW_IDLE);
        we_d    = (state_d == PTW_FILL);
        done_d  = (state_d == PTW_FILL);
        fault_d = (state_d == PTW_FAULT);
        if (state_d == PTW_FILL) begin
            wr_vaddr_d = {vpn_d, 12'd0};
            wr_paddr_d = {pfn_d, 12'd0};
        end else begin
            wr_vaddr_d = wr_vaddr_q;
            wr_paddr_d = wr_paddr_q;
        end
    end

    // State and output registers; reset abandons any walk in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PTW_IDLE;
            vpn_q      <= 20'd0;
            pte1_q     <= 20'd0;
            pfn_q      <= 20'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            we_q       <= 1'b0;
            wr_vaddr_q <= 32'd0;
            wr_paddr_q <= 32'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            pte1_q     <= pte1_d;
            pfn_q      <= pfn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            we_q       <= we_d;
            wr_vaddr_q <= wr_vaddr_d;
            wr_paddr_q <= wr_paddr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.fault        = fault_q;
    assign bus.write_enable = we_q;
    assign bus.wr_vaddr     = wr_vaddr_q;
    assign bus.wr_paddr     = wr_paddr_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_page_walker.sv
// Directed bench for page_walker: a table of single walks with a per-level
// memory responder, plus reset-mid-walk and held-miss sequences.
module tb_page_walker;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    page_walker_if bus();

    page_walker #(.PT_BASE(32'h0010_0000), .ALIAS("PTW")) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] pte1;
        logic [31:0] pte2;
        int          w1;
        int          w2;
        bit          exp_fault;
        int          exp_reqs;
        logic [31:0] exp_a1;
        logic [31:0] exp_a2;
        logic [31:0] exp_wva;
        logic [31:0] exp_wpa;
        int          exp_at;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_lookup(input logic [31:0] addr);
        case (addr)
            32'h0010_0004: return 32'h0020_0001;
            32'h0020_000C: return 32'h00AB_C001;
            32'h0010_0008: return 32'h0030_0001;
            32'h0030_0014: return 32'h0055_5001;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    task automatic run_walk(input vec_t v, input string tag);
        int          reqs = 0, we_cnt = 0, done_cnt = 0, fault_cnt = 0;
        int          ev_at = -1, unstable = 0, drop_err = 0, wait_cnt = 0;
        logic [31:0] addrs [2];
        logic [31:0] held = 32'd0, got_va = 32'd0, got_pa = 32'd0;
        logic        req_prev = 1'b0, ack_prev;
        bit          fin = 1'b0;
        addrs[0] = 32'd0;
        addrs[1] = 32'd0;
        @(negedge clk);
        bus.miss       = 1'b1;
        bus.miss_vaddr = v.va;
        for (int k = 0; k < 60 && !fin; k++) begin
            @(posedge clk);
            @(negedge clk);
            ack_prev    = bus.mem_ack;
            bus.mem_ack = 1'b0;
            if (k == 0) bus.miss = 1'b0;
            if (bus.write_enable) begin
                we_cnt++;
                ev_at  = k;
                got_va = bus.wr_vaddr;
                got_pa = bus.wr_paddr;
            end
            if (bus.done) done_cnt++;
            if (bus.fault) begin
                fault_cnt++;
                ev_at = k;
            end
            if (ack_prev && bus.mem_req) drop_err++;
            if (bus.mem_req) begin
                if (!req_prev) begin
                    if (reqs < 2) addrs[reqs] = bus.mem_addr;
                    reqs++;
                    wait_cnt = 0;
                end else if (bus.mem_addr !== held) begin
                    unstable++;
                end
                held = bus.mem_addr;
                if (wait_cnt == ((reqs == 1) ? v.w1 : v.w2)) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = (reqs == 1) ? v.pte1 : v.pte2;
                end
                wait_cnt++;
            end
            req_prev = bus.mem_req;
            if (k > 0 && !bus.busy) fin = 1'b1;
        end
        chk({tag, " finished"}, 32'(fin), 32'd1);
        chk({tag, " fault count"}, 32'(fault_cnt), v.exp_fault ? 32'd1 : 32'd0);
        chk({tag, " done count"}, 32'(done_cnt), v.exp_fault ? 32'd0 : 32'd1);
        chk({tag, " we count"}, 32'(we_cnt), v.exp_fault ? 32'd0 : 32'd1);
        chk({tag, " mem requests"}, 32'(reqs), 32'(v.exp_reqs));
        chk({tag, " l1 addr"}, addrs[0], v.exp_a1);
        if (v.exp_reqs == 2) chk({tag, " l2 addr"}, addrs[1], v.exp_a2);
        chk({tag, " event cycle"}, 32'(ev_at), 32'(v.exp_at));
        if (!v.exp_fault) begin
            chk({tag, " wr_vaddr"}, got_va, v.exp_wva);
            chk({tag, " wr_paddr"}, got_pa, v.exp_wpa);
        end
        chk({tag, " addr stable"}, 32'(unstable), 32'd0);
        chk({tag, " req drop"}, 32'(drop_err), 32'd0);
    endtask

    initial begin
        int we_n, fault_n, we_at[2], bad_after;
        logic [31:0] wva[2], wpa[2];
        logic req_prev;

        vecs[0] = '{32'h0040_3ABC, 32'h0020_0001, 32'h00AB_C001, 0, 0, 1'b0, 2,
                    32'h0010_0004, 32'h0020_000C, 32'h0040_3000, 32'h00AB_C000, 3};
        vecs[1] = '{32'h0040_3ABC, 32'h0020_0000, 32'h00AB_C001, 0, 0, 1'b1, 1,
                    32'h0010_0004, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1};
        vecs[2] = '{32'h0040_3ABC, 32'h0020_0001, 32'h00AB_C000, 0, 0, 1'b1, 2,
                    32'h0010_0004, 32'h0020_000C, 32'h0000_0000, 32'h0000_0000, 3};
        vecs[3] = '{32'h0040_3ABC, 32'h0020_0001, 32'h00AB_C001, 3, 3, 1'b0, 2,
                    32'h0010_0004, 32'h0020_000C, 32'h0040_3000, 32'h00AB_C000, 9};
        vecs[4] = '{32'hFFFF_F123, 32'hFFFF_F001, 32'h1234_5001, 1, 2, 1'b0, 2,
                    32'h0010_0FFC, 32'hFFFF_FFFC, 32'hFFFF_F000, 32'h1234_5000, 6};
        vecs[5] = '{32'h0000_0000, 32'h0000_1FFF, 32'h0000_0FFF, 2, 0, 1'b0, 2,
                    32'h0010_0000, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 5};
        vecs[6] = '{32'h0040_3ABC, 32'h0000_0000, 32'h00AB_C001, 2, 0, 1'b1, 1,
                    32'h0010_0004, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3};

        reset          = 1'b1;
        bus.miss       = 1'b0;
        bus.miss_vaddr = 32'd0;
        bus.mem_ack    = 1'b0;
        bus.mem_data   = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset outs", {27'd0, bus.done, bus.fault, bus.write_enable, bus.mem_req, 1'b0}, 32'd0);
        chk("reset addrs", bus.mem_addr | bus.wr_vaddr | bus.wr_paddr, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_walk(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the L2 request is outstanding, then a stale ack.
        @(negedge clk);
        bus.miss       = 1'b1;
        bus.miss_vaddr = 32'h0040_3ABC;
        @(posedge clk);
        @(negedge clk);
        bus.miss     = 1'b0;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'h0020_0001;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst l2 req", 32'(bus.mem_req), 32'd1);
        chk("rst l2 addr", bus.mem_addr, 32'h0020_000C);
        reset = 1'b1;
        #1;
        chk("rst async ctl", {27'd0, bus.busy, bus.done, bus.fault, bus.write_enable, bus.mem_req}, 32'd0);
        chk("rst async addrs", bus.mem_addr | bus.wr_vaddr | bus.wr_paddr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'h00AB_C001;
        bad_after = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.busy || bus.write_enable || bus.mem_req || bus.done || bus.fault) bad_after++;
        end
        chk("rst late ack ignored", 32'(bad_after), 32'd0);
        run_walk(vecs[0], "post-reset");

        // Miss held high across two walks; vaddr changes mid-walk.
        we_n = 0;
        fault_n = 0;
        req_prev = 1'b0;
        we_at[0] = -1;
        we_at[1] = -1;
        wva[0] = 32'd0; wva[1] = 32'd0; wpa[0] = 32'd0; wpa[1] = 32'd0;
        @(negedge clk);
        bus.miss       = 1'b1;
        bus.miss_vaddr = 32'h0040_3ABC;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (k == 1) bus.miss_vaddr = 32'h0080_5000;
            if (bus.fault) fault_n++;
            if (bus.write_enable) begin
                if (we_n < 2) begin
                    we_at[we_n] = k;
                    wva[we_n]   = bus.wr_vaddr;
                    wpa[we_n]   = bus.wr_paddr;
                end
                we_n++;
                if (we_n == 2) bus.miss = 1'b0;
            end
            if (bus.mem_req && !req_prev) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = mem_lookup(bus.mem_addr);
            end
            req_prev = bus.mem_req;
        end
        bus.miss = 1'b0;
        chk("held we count", 32'(we_n), 32'd2);
        chk("held fault count", 32'(fault_n), 32'd0);
        chk("held we1 cycle", 32'(we_at[0]), 32'd3);
        chk("held we1 vaddr", wva[0], 32'h0040_3000);
        chk("held we1 paddr", wpa[0], 32'h00AB_C000);
        chk("held we2 cycle", 32'(we_at[1]), 32'd8);
        chk("held we2 vaddr", wva[1], 32'h0080_5000);
        chk("held we2 paddr", wpa[1], 32'h0055_5000);
        chk("held idle at end", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
